// File: rtl/nonbin_update_ctrl_if.sv
// Query/class-register bus between the update controller (master) and its
// environment (slave): the query stream plus the class-register read/write ports.
interface nonbin_update_ctrl_if #(
    parameter int DIMS_PER_CC      = 500,
    parameter int BITWIDTH_PER_DIM = 9
);
    // Handshake: a chunk transfers on a rising clk edge where q_valid && q_ready;
    // q_valid may rise at any time and q_ready only depends on controller state.
    logic                                              q_valid;
    logic                                              q_ready;
    logic [DIMS_PER_CC-1:0]                            q_chunk;
    logic [DIMS_PER_CC-1:0][BITWIDTH_PER_DIM-1:0]      rd_data;
    logic [3:0]                                        rd_seg;
    logic [3:0]                                        wr_seg;
    logic                                              wr_en;
    logic [DIMS_PER_CC-1:0][BITWIDTH_PER_DIM-1:0]      wr_data;

    modport master (
        input  q_valid, q_chunk, rd_data,
        output q_ready, rd_seg, wr_seg, wr_en, wr_data
    );

    modport slave (
        output q_valid, q_chunk, rd_data,
        input  q_ready, rd_seg, wr_seg, wr_en, wr_data
    );
endinterface

// File: rtl/nonbin_update_ctrl.sv
// Segment-serial class-HV update: each query segment adds or subtracts 1 from the
// matching class dimensions with saturation, then writes the segment back.
module nonbin_update_ctrl #(
    parameter int DIMS_PER_CC      = 500,
    parameter int BITWIDTH_PER_DIM = 9,
    parameter int SEQ_CYCLE_COUNT  = 10
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    input  logic                  op_sub,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            dbg_state,
    nonbin_update_ctrl_if.master  bus
);
    localparam int BW = BITWIDTH_PER_DIM;
    localparam logic [3:0]    LAST_SEG = 4'(SEQ_CYCLE_COUNT - 1);
    localparam logic [BW-1:0] MAX_V    = {1'b0, {(BW-1){1'b1}}};
    localparam logic [BW-1:0] MIN_V    = {1'b1, {(BW-1){1'b0}}};
    localparam logic [BW-1:0] ONE      = {{(BW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT_Q = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    typedef logic [DIMS_PER_CC-1:0][BW-1:0] seg_t;

    state_e     state_q, state_d;
    logic [3:0] seg_q, seg_d;
    logic       op_q, op_d;
    seg_t       wr_data_q;
    seg_t       upd;
    logic       capture;

    // A +/-1 step can only overflow from the single extreme value, so clamping
    // reduces to holding that value.
    function automatic logic [BW-1:0] step_dim(input logic [BW-1:0] v,
                                              input logic hit,
                                              input logic sub);
        if (!hit) return v;
        if (sub)  return (v == MIN_V) ? v : v - ONE;
        return (v == MAX_V) ? v : v + ONE;
    endfunction

    always_comb begin
        upd = '0;
        for (int d = 0; d < DIMS_PER_CC; d++) begin
            upd[d] = step_dim(bus.rd_data[d], bus.q_chunk[d], op_q);
        end
    end

    always_comb begin
        state_d = state_q;
        seg_d   = seg_q;
        op_d    = op_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_WAIT_Q;
                    seg_d   = '0;
                    op_d    = op_sub;
                end
            end
            S_WAIT_Q: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (bus.q_valid) begin
                    capture = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // The write strobe is already out this cycle; abort only cancels what follows.
                if (abort) begin
                    state_d = S_IDLE;
                end else if (seg_q == LAST_SEG) begin
                    state_d = S_DONE;
                end else begin
                    seg_d   = seg_q + 4'd1;
                    state_d = S_WAIT_Q;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= S_IDLE;
            seg_q     <= '0;
            op_q      <= 1'b0;
            wr_data_q <= '0;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            op_q    <= op_d;
            if (capture) wr_data_q <= upd;
        end
    end

    assign bus.q_ready = (state_q == S_WAIT_Q);
    assign bus.rd_seg  = seg_q;
    assign bus.wr_seg  = seg_q;
    assign bus.wr_en   = (state_q == S_WRITE);
    assign bus.wr_data = wr_data_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE) && !abort;
    assign dbg_state   = state_q;
endmodule

// File: doc/nonbin_update_ctrl.md
NONBIN_UPDATE_CTRL -- requirements
Module: nonbin_update_ctrl

Interface
REQ-001 The block SHALL have parameter DIMS_PER_CC, default 500: dimensions per segment.
REQ-002 The block SHALL have parameter BITWIDTH_PER_DIM, default 9: signed two's-complement width of each class-HV dimension.
REQ-003 The block SHALL have parameter SEQ_CYCLE_COUNT, default 10: number of segments per class HV, with 2 <= SEQ_CYCLE_COUNT <= 16.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port nrst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port start, input, 1 bit: request one update pass; sampled only in IDLE.
REQ-007 The block SHALL have port op_sub, input, 1 bit: captured at start; 0 = add query, 1 = subtract query.
REQ-008 The block SHALL have port abort, input, 1 bit: terminate the pass without further writes.
REQ-009 The block SHALL have port q_valid, input, 1 bit: the query chunk is valid.
REQ-010 The block SHALL have port q_ready, output, 1 bit: the block accepts the query chunk.
REQ-011 The block SHALL have port q_chunk, input, DIMS_PER_CC bits: binary query segment, bit d = dimension d.
REQ-012 The block SHALL have port rd_data, input, DIMS_PER_CC x BITWIDTH_PER_DIM: class-register segment selected by rd_seg, combinational.
REQ-013 The block SHALL have port rd_seg, output, 4 bits: read segment select, driving the class register's class_ctr.
REQ-014 The block SHALL have port wr_seg, output, 4 bits: write segment select, driving nonbin_ctr.
REQ-015 The block SHALL have port wr_en, output, 1 bit: write strobe, driving adjusting_nonbin_class_hvs.
REQ-016 The block SHALL have port wr_data, output, DIMS_PER_CC x BITWIDTH_PER_DIM: registered write data.
REQ-017 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-018 The block SHALL have port done, output, 1 bit: one-cycle pulse when a pass completes.

Function
REQ-019 The FSM SHALL have exactly the states IDLE, WAIT_Q, WRITE and DONE, with a 4-bit segment counter seg.
REQ-020 In IDLE with start=1, the block SHALL go to WAIT_Q, set seg=0 and latch op_sub; start outside IDLE SHALL be ignored.
REQ-021 In WAIT_Q, q_ready SHALL be 1 and rd_seg SHALL equal seg; q_ready SHALL be 0 in all other states.
REQ-022 On q_valid&&q_ready, for each dimension d, wr_data[d] SHALL register sat(rd_data[d] + (q_chunk[d] ? (op ? -1 : +1) : 0)) and the FSM SHALL go to WRITE.
REQ-023 Saturation SHALL clamp to [-2^(BW-1), 2^(BW-1)-1] (default -256..255): 255+1 -> 255 and -256-1 -> -256.
REQ-024 Dimensions whose q_chunk bit is 0 SHALL be written back unchanged.
REQ-025 In WRITE, wr_en SHALL be 1 for exactly one cycle with wr_seg=seg.
REQ-026 From WRITE, if seg==SEQ_CYCLE_COUNT-1 the FSM SHALL go to DONE; otherwise seg SHALL increment and the FSM SHALL return to WAIT_Q.
REQ-027 In DONE, done SHALL be 1 for one cycle, and the FSM SHALL then go to IDLE.
REQ-028 Each segment SHALL take 1 + (q_valid wait) + 1 cycles; with q_valid held high, a pass SHALL take 2*SEQ_CYCLE_COUNT+1 cycles from start to done inclusive of DONE.
REQ-029 Because rd_seg selects the segment being written only after the write completes, reading a stale segment SHALL be impossible.
REQ-030 abort=1 in WAIT_Q or DONE SHALL force IDLE on the next edge with no wr_en and no done.
REQ-031 In WRITE, the write SHALL still occur, but the next state SHALL be IDLE with no done.
REQ-032 abort in IDLE SHALL have no effect.
REQ-033 abort SHALL take priority over start in the same cycle.
REQ-034 In IDLE and DONE, rd_seg and wr_seg SHALL hold seg, and wr_en SHALL be 0.
REQ-035 wr_data SHALL hold its value except on a handshake.

Reset
REQ-036 While nrst=0, the block SHALL be in state IDLE with seg=0, op=0, wr_data=0 and rd_seg=wr_seg=0.
REQ-037 While nrst=0, wr_en, q_ready, busy and done SHALL all be 0.
REQ-038 Asserting nrst=0 mid-pass SHALL abandon the pass immediately, with no partial write after reset release.
REQ-039 After nrst rises, the block SHALL wait for a new start.

Verification
REQ-040 Add pass: rd_data all 5, q_chunk alternating 1/0, op_sub=0, q_valid constant -> 10 writes with wr_data 6/5 alternating, wr_seg 0..9, done at cycle 21.
REQ-041 Saturation: rd_data dims 255 and -256 with q bits 1, run add then sub -> 255 stays 255 on add, -256 stays -256 on sub.
REQ-042 Backpressure: q_valid low 3 cycles per segment -> q_ready held, no wr_en until handshake, total 51 cycles.
REQ-043 Abort in WAIT_Q at seg 4 -> exactly 4 writes (segs 0-3), no done, busy=0 next cycle.
REQ-044 start while busy and start+abort together -> no restart, no extra writes, IDLE retained.
REQ-045 Async reset asserted at seg 6 WRITE cycle -> wr_en/busy drop immediately; after release, a fresh start restarts at seg 0.
